// File: rtl/mux_seq.sv
// mux_seq: registered N-lane operand selector with a valid/ready output.
// Mode 0 presents one chosen lane; mode 1 sweeps lanes 0..N-1 and then pulses done_flag.
module mux_seq #(
    parameter int DW   = 4,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            reset_a,
    input  logic            start,
    input  logic            mode,
    input  logic [SELW-1:0] sel_in,
    input  logic [N*DW-1:0] mux_in,
    input  logic            out_ready,
    output logic [DW-1:0]   mux_out,
    output logic            out_valid,
    output logic [SELW-1:0] cur_sel,
    output logic            busy,
    output logic            done_flag,
    output logic            sel_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            err_q, err_d;

    logic            xfer;
    logic [SELW-1:0] start_sel;
    logic [SELW-1:0] sel_next;
    logic [DW-1:0]   lane_start;
    logic [DW-1:0]   lane_next;
    logic            start_in_range;

    // An index with no matching lane yields zero data.
    function automatic logic [DW-1:0] pick_lane(input logic [SELW-1:0] s,
                                                input logic [N*DW-1:0] bus);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SELW'(k)) begin
                r = bus[k*DW +: DW];
            end
        end
        return r;
    endfunction

    function automatic logic lane_exists(input logic [SELW-1:0] s);
        logic r;
        r = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (s == SELW'(k)) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign xfer           = valid_q && out_ready;
    assign start_sel      = mode ? {SELW{1'b0}} : sel_in;
    assign sel_next       = SELW'(sel_q + 1'b1);
    assign lane_start     = pick_lane(start_sel, mux_in);
    assign lane_next      = pick_lane(sel_next, mux_in);
    assign start_in_range = lane_exists(sel_in);

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // mux_in is only sampled on edges that load a new lane, so held data stays stable.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    valid_d = 1'b1;
                    sel_d   = start_sel;
                    data_d  = lane_start;
                    state_d = mode ? SWEEP : HOLD;
                    if (!mode && !start_in_range) begin
                        err_d = 1'b1;
                    end
                end
            end
            SWEEP: begin
                if (xfer) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        sel_d   = '0;
                    end else begin
                        sel_d  = sel_next;
                        data_d = lane_next;
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mux_out   = data_q;
    assign out_valid = valid_q;
    assign cur_sel   = sel_q;
    assign busy      = (state_q != IDLE);
    assign done_flag = (state_q == DONE);
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_seq.sv
// Bench for mux_seq: directed vectors, a transaction-level model checked every cycle,
// and literal expectations on the accepted-lane sequences.
module tb_mux_seq;

    localparam int LANES = 4;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic        mode;
    logic [1:0]  selIn;
    logic [15:0] muxIn;
    logic        outReady;
    logic [3:0]  muxOut;
    logic        outValid;
    logic [1:0]  curSel;
    logic        busy;
    logic        doneFlag;
    logic        selErr;

    logic        start5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [19:0] muxIn5;
    logic        ready5;
    logic [3:0]  out5;
    logic        valid5;
    logic [2:0]  cur5;
    logic        busy5;
    logic        done5;
    logic        err5;

    int total = 0;
    int bad   = 0;

    int         mPhase  = 0;
    bit         mManual = 1'b0;
    int         mLane   = 0;
    logic [3:0] mData   = '0;
    bit         mValid  = 1'b0;
    bit         mErr    = 1'b0;

    logic [3:0] xferLog[$];
    int         doneCount = 0;
    logic       prevValid = 1'b0;
    logic [3:0] prevOut   = '0;

    mux_seq #(.DW(4), .N(4), .SELW(2)) dut (
        .clk(clk), .reset_a(reset_a), .start(start), .mode(mode),
        .sel_in(selIn), .mux_in(muxIn), .out_ready(outReady),
        .mux_out(muxOut), .out_valid(outValid), .cur_sel(curSel),
        .busy(busy), .done_flag(doneFlag), .sel_err(selErr)
    );

    mux_seq #(.DW(4), .N(5), .SELW(3)) dut5 (
        .clk(clk), .reset_a(reset_a), .start(start5), .mode(mode5),
        .sel_in(sel5), .mux_in(muxIn5), .out_ready(ready5),
        .mux_out(out5), .out_valid(valid5), .cur_sel(cur5),
        .busy(busy5), .done_flag(done5), .sel_err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] laneVal(input int k, input logic [15:0] bus);
        if (k < 0 || k >= LANES) return 4'h0;
        return 4'((bus >> (4 * k)) & 16'h000F);
    endfunction

    // Transaction-level view: an operation presents a list of lanes one at a time,
    // each accepted when ready is high, followed by a single done cycle.
    task automatic modelStep();
        if (!reset_a) begin
            mPhase = 0; mManual = 1'b0; mLane = 0; mData = '0; mValid = 1'b0; mErr = 1'b0;
        end else begin
            case (mPhase)
                0: if (start) begin
                    mPhase  = 1;
                    mManual = !mode;
                    mLane   = mode ? 0 : int'(selIn);
                    mData   = laneVal(mLane, muxIn);
                    mValid  = 1'b1;
                    if (!mode && int'(selIn) >= LANES) mErr = 1'b1;
                end
                1: if (outReady) begin
                    if (mManual || mLane == LANES - 1) begin
                        mPhase = 2;
                        mValid = 1'b0;
                        if (!mManual) mLane = 0;
                    end else begin
                        mLane = mLane + 1;
                        mData = laneVal(mLane, muxIn);
                    end
                end
                default: mPhase = 0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset_a && prevValid && outReady) xferLog.push_back(prevOut);
            modelStep();
            #1;
            checkOutput("mux_out",   int'(muxOut),   int'(mData));
            checkOutput("out_valid", int'(outValid), int'(mValid));
            checkOutput("cur_sel",   int'(curSel),   mLane);
            checkOutput("busy",      int'(busy),     int'(mPhase != 0));
            checkOutput("done_flag", int'(doneFlag), int'(mPhase == 2));
            checkOutput("sel_err",   int'(selErr),   int'(mErr));
            prevValid = outValid;
            prevOut   = muxOut;
            if (doneFlag) doneCount++;
        end
    end

    task automatic applyStimulus(input logic s, input logic m, input logic [1:0] sl,
                                 input logic r);
        @(negedge clk);
        start    = s;
        mode     = m;
        selIn    = sl;
        outReady = r;
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic checkLog(input string tag, input logic [3:0] exp[$]);
        checkOutput({tag, "_count"}, xferLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xferLog.size(); i++) begin
            checkOutput($sformatf("%s_lane%0d", tag, i), int'(xferLog[i]), int'(exp[i]));
        end
        xferLog.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneBefore;
        reset_a = 1'b0;
        start = 1'b0; mode = 1'b0; selIn = '0; outReady = 1'b0; muxIn = 16'hD6A3;
        start5 = 1'b0; mode5 = 1'b0; sel5 = '0; ready5 = 1'b0; muxIn5 = 20'h1D6A3;

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(negedge clk) reset_a = 1'b1;
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkOutput("idle_mux_out", int'(muxOut), 0);
        checkOutput("idle_valid", int'(outValid), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_done", int'(doneFlag), 0);

        $display("[TB] auto sweep, ready held high");
        doneBefore = doneCount;
        applyStimulus(1, 1, 0, 1);
        peek();
        checkOutput("sweep_first_out", int'(muxOut), 4'h3);
        checkOutput("sweep_first_sel", int'(curSel), 0);
        checkOutput("sweep_first_valid", int'(outValid), 1);
        repeat (7) applyStimulus(0, 0, 0, 1);
        checkLog("sweep1", '{4'h3, 4'hA, 4'h6, 4'hD});
        checkOutput("sweep1_done_pulses", doneCount - doneBefore, 1);
        checkOutput("sweep1_busy_after", int'(busy), 0);

        $display("[TB] auto sweep, ready toggling, data changed while lane 1 held");
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        muxIn = 16'h0000;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 1);
        checkLog("sweep2", '{4'h3, 4'hA, 4'h0, 4'h0});
        muxIn = 16'hD6A3;

        $display("[TB] manual select lane 2");
        doneBefore = doneCount;
        applyStimulus(1, 0, 2, 0);
        peek();
        checkOutput("manual_out", int'(muxOut), 4'h6);
        checkOutput("manual_sel", int'(curSel), 2);
        repeat (3) applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 0, 3, 1);
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkLog("manual", '{4'h6});
        checkOutput("manual_done_pulses", doneCount - doneBefore, 1);
        checkOutput("manual_sel_err", int'(selErr), 0);

        $display("[TB] start pulses while busy");
        doneBefore = doneCount;
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 2, 1);
        applyStimulus(1, 1, 0, 1);
        repeat (7) applyStimulus(0, 0, 0, 1);
        checkLog("restart", '{4'h3, 4'hA, 4'h6, 4'hD, 4'h3, 4'hA, 4'h6, 4'hD});
        checkOutput("restart_done_pulses", doneCount - doneBefore, 2);

        $display("[TB] reset mid-sweep");
        doneBefore = doneCount;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        #2 reset_a = 1'b0;
        #1;
        checkOutput("rst_mux_out", int'(muxOut), 0);
        checkOutput("rst_valid", int'(outValid), 0);
        checkOutput("rst_sel", int'(curSel), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(doneFlag), 0);
        applyStimulus(0, 0, 0, 1);
        @(negedge clk) reset_a = 1'b1;
        repeat (4) applyStimulus(0, 0, 0, 1);
        checkOutput("rst_no_done", doneCount - doneBefore, 0);
        checkLog("rst", '{});

        $display("[TB] N=5 instance, out-of-range select");
        @(negedge clk) begin start5 = 1'b1; mode5 = 1'b0; sel5 = 3'd6; ready5 = 1'b0; end
        peek();
        checkOutput("n5_bad_out", int'(out5), 0);
        checkOutput("n5_bad_valid", int'(valid5), 1);
        checkOutput("n5_bad_sel", int'(cur5), 6);
        checkOutput("n5_bad_err", int'(err5), 1);
        @(negedge clk) begin start5 = 1'b0; ready5 = 1'b1; end
        peek();
        checkOutput("n5_done", int'(done5), 1);
        checkOutput("n5_done_valid", int'(valid5), 0);
        @(negedge clk) ready5 = 1'b0;
        peek();
        checkOutput("n5_idle_busy", int'(busy5), 0);
        checkOutput("n5_err_sticky", int'(err5), 1);
        @(negedge clk) begin start5 = 1'b1; sel5 = 3'd4; end
        peek();
        checkOutput("n5_lane4_out", int'(out5), 4'h1);
        checkOutput("n5_lane4_err", int'(err5), 1);
        @(negedge clk) begin start5 = 1'b0; reset_a = 1'b0; end
        #1;
        checkOutput("n5_rst_err", int'(err5), 0);
        checkOutput("n5_rst_valid", int'(valid5), 0);
        @(negedge clk) reset_a = 1'b1;
        repeat (2) applyStimulus(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
